mem1_stage_t: RTL and testbench
===============================

MEM1_STAGE_T -- requirements
Module: mem1_stage_t

Interface
REQ-001 Parameter: MISALIGN_DROP, default 1, meaning that misaligned accesses are suppressed (no bus request) and their register write is cancelled.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 ex_valid  in  1  EX-stage instruction valid.
REQ-005 ex_alu  in  32  ALU result, also the memory address.
REQ-006 ex_pc, ex_stdat  in  32 each  instruction PC and store data.
REQ-007 ex_rd  in  5 / ex_rfwt_sel  in  2 / ex_wten  in  1  destination register, write-back select, and write enable.
REQ-008 ex_memop  in  4  memory operation code.
REQ-009 dm_req, dm_we  out  1 / dm_addr, dm_wdata  out  32 / dm_be  out  4  data-bus request outputs.
REQ-010 dm_gnt  in  1 / dm_rvalid  in  1 / dm_rdata  in  32  bus grant, read-response valid, and read data.
REQ-011 mem_stall  out  1  EX must hold its outputs while this is high.
REQ-012 wb1_valid, wb1_wten  out  1 / wb1_alu, wb1_memdat, wb1_pc  out  32 / wb1_rd  out  5 / wb1_rfwt_sel  out  2  registered WB1 inputs.
REQ-013 mem_misalign  out  1  registered flag, high for one cycle alongside the dropped instruction.

Function
REQ-014 Memop codes: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 SHALL be treated as NONE.
REQ-015 FSM states: IDLE, REQ, WAIT; transitions are listed below.
REQ-016 IDLE with ex_valid, memop not NONE and an aligned address: drive dm_req=1 combinationally; on dm_gnt go to WAIT for loads, or complete for stores; without dm_gnt go to REQ.
REQ-017 REQ: dm_req and all dm_* outputs SHALL stay stable from the latched request; on dm_gnt go to WAIT (loads) or IDLE with completion (stores).
REQ-018 WAIT: on dm_rvalid, capture the extracted load data and go to IDLE with completion; a dm_rvalid seen in IDLE or REQ SHALL be ignored.
REQ-019 mem_stall = ex_valid and memop not NONE and not completing this cycle; it also covers every cycle spent in REQ or WAIT.
REQ-020 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; bytes are always aligned.
REQ-021 Misaligned access with MISALIGN_DROP=1: no dm_req; the instruction passes in one cycle with wb1_wten=0 and mem_misalign=1.
REQ-022 dm_addr SHALL be {addr[31:2],2'b00}.
REQ-023 dm_be: SB gives 4'b0001 shifted left by addr[1:0]; SH gives 4'b0011 shifted left by addr[1]*2; SW gives 4'hF; loads give 4'hF.
REQ-024 dm_wdata: store data replicated, i.e. the byte repeated 4x for SB and the halfword repeated 2x for SH.
REQ-025 Load extraction: select a byte or halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-026 A non-memory instruction SHALL complete in the same cycle, with latency 1 to the wb1_* outputs.
REQ-027 Completion edge: all wb1_* outputs load from ex_* (wb1_memdat from extraction, or 0 for non-loads), and wb1_valid=1.
REQ-028 Any edge without completion SHALL load wb1_valid=0 and wb1_wten=0 (a bubble); the other wb1_* outputs keep their values.
REQ-029 An ex_valid=0 cycle SHALL produce a bubble with no stall.

Reset
REQ-030 On RST: the FSM goes to IDLE, and wb1_valid, wb1_wten, mem_misalign are set to 0.
REQ-031 On RST: wb1_alu, wb1_memdat, wb1_pc, wb1_rd and wb1_rfwt_sel are set to 0.
REQ-032 dm_req SHALL be 0 during any cycle with RST=1.
REQ-033 Reset in REQ or WAIT SHALL abandon the transaction; a late dm_rvalid SHALL be ignored.

Structure
REQ-034 Package mem1_pkg SHALL hold the memop codes, the FSM state encoding, and the RFWT_ALU/PC/MEM/ZERO constants (0-3).
REQ-035 Load extraction SHALL be a combinational sub-module, mem1_ldext_t, with inputs rdata, addr[1:0], memop and output data.

Verification
REQ-036 ALU op, ex_alu=0x1234, rd=5, wten=1 -> next cycle wb1_valid=1, wb1_alu=0x1234, wb1_rd=5, and mem_stall is never asserted.
REQ-037 LB at addr 0x103, dm_gnt immediate, dm_rvalid 2 cycles later with rdata=0x80FF_0000 -> dm_addr=0x100; wb1_memdat=0xFFFF_FF80; mem_stall high for 3 cycles.
REQ-038 SH at addr 0x202, stdat=0xABCD, dm_gnt delayed 3 cycles -> dm_be=4'b1100, dm_wdata=0xABCD_ABCD held stable in REQ; completes on grant with wb1_valid=1.
REQ-039 LW at addr 0x101 -> no dm_req, mem_misalign=1, wb1_wten=0, no stall.
REQ-040 LHU at addr 0x002, RST asserted in WAIT, dm_rvalid arriving after reset -> FSM in IDLE, wb1_valid=0, response ignored.
REQ-041 Back-to-back LW then ADD -> ADD held by mem_stall until the LW completes; wb1 outputs show the LW then the ADD on consecutive completions.

Source files
------------

// File: rtl/mem1_pkg.sv
// Shared definitions for the MEM1 pipeline stage: memop codes, FSM states,
// write-back select constants and small memop decode helpers.
package mem1_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned RFWT_W = 2;

    localparam logic [OP_W-1:0] MEMOP_NONE = 4'd0;
    localparam logic [OP_W-1:0] MEMOP_LB   = 4'd1;
    localparam logic [OP_W-1:0] MEMOP_LH   = 4'd2;
    localparam logic [OP_W-1:0] MEMOP_LW   = 4'd3;
    localparam logic [OP_W-1:0] MEMOP_LBU  = 4'd4;
    localparam logic [OP_W-1:0] MEMOP_LHU  = 4'd5;
    localparam logic [OP_W-1:0] MEMOP_SB   = 4'd6;
    localparam logic [OP_W-1:0] MEMOP_SH   = 4'd7;
    localparam logic [OP_W-1:0] MEMOP_SW   = 4'd8;

    localparam logic [RFWT_W-1:0] RFWT_ALU  = 2'd0;
    localparam logic [RFWT_W-1:0] RFWT_PC   = 2'd1;
    localparam logic [RFWT_W-1:0] RFWT_MEM  = 2'd2;
    localparam logic [RFWT_W-1:0] RFWT_ZERO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Codes 9-15 decode as neither load nor store, i.e. NONE.
    function automatic logic memop_is_load(input logic [OP_W-1:0] op);
        logic r;
        r = (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
            (op == MEMOP_LBU) || (op == MEMOP_LHU);
        return r;
    endfunction

    function automatic logic memop_is_store(input logic [OP_W-1:0] op);
        logic r;
        r = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
        return r;
    endfunction

    function automatic logic memop_aligned(input logic [OP_W-1:0] op, input logic [1:0] a);
        logic r;
        r = 1'b1;
        if ((op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH)) begin
            r = ~a[0];
        end else if ((op == MEMOP_LW) || (op == MEMOP_SW)) begin
            r = (a == 2'b00);
        end
        return r;
    endfunction

endpackage

// File: rtl/mem1_ldext_t.sv
// Load data extraction: picks the byte/halfword lane from a bus word and
// sign- or zero-extends it according to the load type.
module mem1_ldext_t
    import mem1_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [OP_W-1:0] memop,
    output logic [XLEN-1:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (memop)
            MEMOP_LB:  data = {{24{w_byte[7]}}, w_byte};
            MEMOP_LBU: data = {24'd0, w_byte};
            MEMOP_LH:  data = {{16{w_half[15]}}, w_half};
            MEMOP_LHU: data = {16'd0, w_half};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem1_stage_t.sv
// MEM1 pipeline stage: issues data-bus requests for loads/stores, stalls EX
// until the access completes, and registers the results towards WB1.
module mem1_stage_t
    import mem1_pkg::*;
#(
    parameter bit MISALIGN_DROP = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_alu,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_stdat,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic [RFWT_W-1:0] ex_rfwt_sel,
    input  logic              ex_wten,
    input  logic [OP_W-1:0]   ex_memop,
    output logic              dm_req,
    output logic              dm_we,
    output logic [XLEN-1:0]   dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    output logic [BE_W-1:0]   dm_be,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [XLEN-1:0]   dm_rdata,
    output logic              mem_stall,
    output logic              wb1_valid,
    output logic              wb1_wten,
    output logic [XLEN-1:0]   wb1_alu,
    output logic [XLEN-1:0]   wb1_memdat,
    output logic [XLEN-1:0]   wb1_pc,
    output logic [RD_W-1:0]   wb1_rd,
    output logic [RFWT_W-1:0] wb1_rfwt_sel,
    output logic              mem_misalign
);

    state_e r_state;
    state_e w_state_nxt;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_drop;
    logic              w_access;
    logic              w_complete;
    logic              w_complete_drop;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_addr;
    logic [XLEN-1:0]   w_ldata;
    logic [XLEN-1:0]   w_memdat;

    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [OP_W-1:0]   r_memop;
    logic [1:0]        r_lane;

    // Decode of the instruction presented by EX.
    always_comb begin
        w_is_load  = memop_is_load(ex_memop);
        w_is_store = memop_is_store(ex_memop);
        w_is_mem   = w_is_load | w_is_store;
        w_drop     = w_is_mem & ~memop_aligned(ex_memop, ex_alu[1:0]) & MISALIGN_DROP;
        w_access   = ex_valid & w_is_mem & ~w_drop;
        w_addr     = {ex_alu[31:2], 2'b00};

        w_be    = 4'hF;
        w_wdata = ex_stdat;
        case (ex_memop)
            MEMOP_SB: begin
                w_be    = 4'b0001 << ex_alu[1:0];
                w_wdata = {4{ex_stdat[7:0]}};
            end
            MEMOP_SH: begin
                w_be    = ex_alu[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_stdat[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = ex_stdat;
            end
        endcase
    end

    // Lane/type are taken from the latched request so WAIT never depends on EX.
    mem1_ldext_t u_ldext (
        .rdata (dm_rdata),
        .addr  (r_lane),
        .memop (r_memop),
        .data  (w_ldata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, bus outputs, completion and stall.
    always_comb begin
        w_state_nxt     = r_state;
        dm_req          = 1'b0;
        dm_we           = r_we;
        dm_addr         = r_addr;
        dm_wdata        = r_wdata;
        dm_be           = r_be;
        w_complete      = 1'b0;
        w_complete_drop = 1'b0;
        w_memdat        = '0;

        case (r_state)
            ST_IDLE: begin
                dm_we    = w_is_store;
                dm_addr  = w_addr;
                dm_wdata = w_wdata;
                dm_be    = w_be;
                if (w_access) begin
                    dm_req = 1'b1;
                    if (!dm_gnt) begin
                        w_state_nxt = ST_REQ;
                    end else if (w_is_store) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (ex_valid) begin
                    w_complete      = 1'b1;
                    w_complete_drop = w_drop;
                end
            end
            ST_REQ: begin
                dm_req = 1'b1;
                if (dm_gnt) begin
                    if (r_we) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dm_rvalid) begin
                    w_complete  = 1'b1;
                    w_memdat    = w_ldata;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        mem_stall = ((r_state != ST_IDLE) | (ex_valid & w_is_mem)) & ~w_complete;

        if (RST) begin
            dm_req = 1'b0;
        end
    end

    // Request latch: refreshed every IDLE cycle, frozen while REQ/WAIT run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_memop <= MEMOP_NONE;
            r_lane  <= 2'd0;
        end else if (r_state == ST_IDLE) begin
            r_we    <= w_is_store;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_memop <= ex_memop;
            r_lane  <= ex_alu[1:0];
        end
    end

    // WB1 registers: full load on completion, bubble otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb1_valid    <= 1'b0;
            wb1_wten     <= 1'b0;
            wb1_alu      <= '0;
            wb1_memdat   <= '0;
            wb1_pc       <= '0;
            wb1_rd       <= '0;
            wb1_rfwt_sel <= '0;
            mem_misalign <= 1'b0;
        end else if (w_complete) begin
            wb1_valid    <= 1'b1;
            wb1_wten     <= ex_wten & ~w_complete_drop;
            wb1_alu      <= ex_alu;
            wb1_memdat   <= w_memdat;
            wb1_pc       <= ex_pc;
            wb1_rd       <= ex_rd;
            wb1_rfwt_sel <= ex_rfwt_sel;
            mem_misalign <= w_complete_drop;
        end else begin
            wb1_valid    <= 1'b0;
            wb1_wten     <= 1'b0;
            mem_misalign <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem1_stage_t.sv
// Self-checking bench for mem1_stage_t: directed scenarios plus randomized
// instructions with a randomized bus, checked against a transaction-level model.
module tb_mem1_stage_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid;
    logic [31:0] ex_alu, ex_pc, ex_stdat;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_rfwt_sel;
    logic        ex_wten;
    logic [3:0]  ex_memop;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_stall;
    logic        wb1_valid, wb1_wten;
    logic [31:0] wb1_alu, wb1_memdat, wb1_pc;
    logic [4:0]  wb1_rd;
    logic [1:0]  wb1_rfwt_sel;
    logic        mem_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected held WB1 payload, used to check bubbles keep the old values.
    logic [31:0] e_alu = 0, e_memdat = 0, e_pc = 0;
    logic [4:0]  e_rd = 0;
    logic [1:0]  e_sel = 0;

    mem1_stage_t #(.MISALIGN_DROP(1'b1)) dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_pc(ex_pc),
        .ex_stdat(ex_stdat), .ex_rd(ex_rd), .ex_rfwt_sel(ex_rfwt_sel), .ex_wten(ex_wten),
        .ex_memop(ex_memop), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .mem_stall(mem_stall), .wb1_valid(wb1_valid),
        .wb1_wten(wb1_wten), .wb1_alu(wb1_alu), .wb1_memdat(wb1_memdat), .wb1_pc(wb1_pc),
        .wb1_rd(wb1_rd), .wb1_rfwt_sel(wb1_rfwt_sel), .mem_misalign(mem_misalign)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_load(input int op);  return op >= 1 && op <= 5; endfunction
    function automatic bit m_store(input int op); return op >= 6 && op <= 8; endfunction

    function automatic int m_size(input int op);
        if (op == 1 || op == 4 || op == 6) return 1;
        if (op == 2 || op == 5 || op == 7) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input int op, input logic [31:0] a);
        if (!(m_load(op) || m_store(op))) return 1'b0;
        return (a % m_size(op)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input int op, input logic [31:0] a);
        if (op == 6) return 32'(1 << (a % 4));
        if (op == 7) return 32'(3 << ((a % 4) / 2 * 2));
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] d);
        if (op == 6) return (d % 256) * 32'h0101_0101;
        if (op == 7) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ext(input int op, input logic [31:0] w, input logic [31:0] a);
        logic [31:0] v;
        if (m_size(op) == 1) begin
            v = (w >> (8 * (a % 4))) % 256;
            if (op == 1 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (m_size(op) == 2) begin
            v = (w >> (16 * ((a % 4) / 2))) % 65536;
            if (op == 2 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Runs one instruction from EX through completion; the bench plays the bus.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run_instr(input string nm, input int op, input logic [31:0] addr,
                             input logic [31:0] stdat, input logic [31:0] pc, input logic [4:0] rd,
                             input logic [1:0] sel, input logic wten, input int gdly,
                             input int rdly, input logic [31:0] rdata, input bit spur);
        bit mem, mis, expreq, ld, done, granted, waiting;
        int nreq, nwait, nstall, exp_stall;
        logic [31:0] exp_mem;
        mem    = m_load(op) || m_store(op);
        mis    = m_mis(op, addr);
        expreq = mem && !mis;
        ld     = m_load(op) && expreq;
        exp_stall = !expreq ? 0 : (ld ? gdly + 1 + rdly : gdly);
        exp_mem   = ld ? m_ext(op, rdata, addr) : 32'h0;
        ex_valid = 1'b1; ex_memop = 4'(op); ex_alu = addr; ex_stdat = stdat;
        ex_pc = pc; ex_rd = rd; ex_rfwt_sel = sel; ex_wten = wten;
        done = 0; granted = 0; waiting = 0; nreq = 0; nwait = 0; nstall = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            dm_gnt = 1'b0;
            dm_rvalid = 1'b0;
            dm_rdata = $urandom;
            if (!waiting && spur) dm_rvalid = ($urandom_range(0, 1) == 0);
            #1;
            if (!waiting) begin
                if (expreq) begin
                    check_eq({nm, ".dm_req"}, 32'(dm_req), 32'd1);
                    check_eq({nm, ".dm_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
                    check_eq({nm, ".dm_be"}, 32'(dm_be), m_be(op, addr));
                    check_eq({nm, ".dm_we"}, 32'(dm_we), 32'(m_store(op)));
                    if (m_store(op)) check_eq({nm, ".dm_wdata"}, dm_wdata, m_wdata(op, stdat));
                    if (nreq == gdly) begin dm_gnt = 1'b1; granted = 1; end
                    nreq++;
                end else begin
                    check_eq({nm, ".dm_req_none"}, 32'(dm_req), 32'd0);
                end
            end else begin
                check_eq({nm, ".dm_req_wait"}, 32'(dm_req), 32'd0);
                if (nwait == rdly) begin dm_rvalid = 1'b1; dm_rdata = rdata; end
                nwait++;
            end
            @(negedge CLK);
            if (mem_stall) nstall++; else done = 1;
            @(posedge CLK);
            #1;
            if (granted && ld) waiting = 1;
        end
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        if (!done) check_eq({nm, ".timeout"}, 32'd0, 32'd1);
        check_eq({nm, ".stall_cycles"}, 32'(nstall), 32'(exp_stall));
        check_eq({nm, ".wb1_valid"}, 32'(wb1_valid), 32'd1);
        check_eq({nm, ".wb1_wten"}, 32'(wb1_wten), 32'(wten && !mis));
        check_eq({nm, ".wb1_alu"}, wb1_alu, addr);
        check_eq({nm, ".wb1_pc"}, wb1_pc, pc);
        check_eq({nm, ".wb1_rd"}, 32'(wb1_rd), 32'(rd));
        check_eq({nm, ".wb1_rfwt_sel"}, 32'(wb1_rfwt_sel), 32'(sel));
        check_eq({nm, ".wb1_memdat"}, wb1_memdat, exp_mem);
        check_eq({nm, ".mem_misalign"}, 32'(mem_misalign), 32'(mis));
        e_alu = addr; e_pc = pc; e_rd = rd; e_sel = sel; e_memdat = exp_mem;
    endtask

    // One ex_valid=0 cycle with junk on the other EX inputs and a stray rvalid.
    task automatic bubble();
        ex_valid = 1'b0; ex_memop = 4'($urandom_range(0, 15)); ex_alu = $urandom;
        ex_wten = 1'b1; dm_gnt = 1'b0; dm_rvalid = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
        #1;
        check_eq("bubble.dm_req", 32'(dm_req), 32'd0);
        @(negedge CLK);
        check_eq("bubble.stall", 32'(mem_stall), 32'd0);
        @(posedge CLK);
        #1;
        dm_rvalid = 1'b0;
        check_eq("bubble.wb1_valid", 32'(wb1_valid), 32'd0);
        check_eq("bubble.wb1_wten", 32'(wb1_wten), 32'd0);
        check_eq("bubble.mem_misalign", 32'(mem_misalign), 32'd0);
        check_eq("bubble.wb1_alu_hold", wb1_alu, e_alu);
        check_eq("bubble.wb1_memdat_hold", wb1_memdat, e_memdat);
        check_eq("bubble.wb1_pc_hold", wb1_pc, e_pc);
        check_eq("bubble.wb1_rd_hold", 32'(wb1_rd), 32'(e_rd));
    endtask

    task automatic check_wb_zero(input string nm);
        check_eq({nm, ".wb1_valid"}, 32'(wb1_valid), 32'd0);
        check_eq({nm, ".wb1_wten"}, 32'(wb1_wten), 32'd0);
        check_eq({nm, ".mem_misalign"}, 32'(mem_misalign), 32'd0);
        check_eq({nm, ".wb1_alu"}, wb1_alu, 32'd0);
        check_eq({nm, ".wb1_memdat"}, wb1_memdat, 32'd0);
        check_eq({nm, ".wb1_pc"}, wb1_pc, 32'd0);
        check_eq({nm, ".wb1_rd"}, 32'(wb1_rd), 32'd0);
        check_eq({nm, ".wb1_rfwt_sel"}, 32'(wb1_rfwt_sel), 32'd0);
        e_alu = 0; e_memdat = 0; e_pc = 0; e_rd = 0; e_sel = 0;
    endtask

    initial begin
        RST = 1'b1;
        ex_valid = 1'b1; ex_memop = 4'd3; ex_alu = 32'h40; ex_pc = 0; ex_stdat = 0;
        ex_rd = 0; ex_rfwt_sel = 0; ex_wten = 1'b1;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 0;
        #1;
        check_eq("reset.dm_req", 32'(dm_req), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_eq("reset.dm_req2", 32'(dm_req), 32'd0);
        check_wb_zero("reset");
        RST = 1'b0;
        ex_valid = 1'b0;

        run_instr("alu", 0, 32'h1234, 0, 32'h1000, 5'd5, 2'd0, 1'b1, 0, 0, 0, 0);
        run_instr("lb", 1, 32'h103, 0, 32'h1004, 5'd6, 2'd2, 1'b1, 0, 2, 32'h80FF_0000, 0);
        run_instr("sh", 7, 32'h202, 32'h0000_ABCD, 32'h1008, 5'd0, 2'd0, 1'b0, 3, 0, 0, 0);
        run_instr("lw_mis", 3, 32'h101, 0, 32'h100C, 5'd7, 2'd2, 1'b1, 0, 0, 0, 0);
        bubble();
        run_instr("lw_b2b", 3, 32'h300, 0, 32'h1010, 5'd8, 2'd2, 1'b1, 1, 1, 32'hCAFE_F00D, 1);
        run_instr("add_b2b", 0, 32'h5555, 0, 32'h1014, 5'd9, 2'd0, 1'b1, 0, 0, 0, 0);
        run_instr("op_hi", 12, 32'h7, 0, 32'h1018, 5'd10, 2'd1, 1'b1, 0, 0, 0, 0);

        // Reset while an LHU sits in WAIT, then a late response.
        ex_valid = 1'b1; ex_memop = 4'd5; ex_alu = 32'h2; ex_pc = 32'h2000;
        ex_rd = 5'd3; ex_rfwt_sel = 2'd2; ex_wten = 1'b1;
        #1;
        check_eq("rst_wait.dm_req", 32'(dm_req), 32'd1);
        dm_gnt = 1'b1;
        @(posedge CLK);
        #1;
        dm_gnt = 1'b0; RST = 1'b1;
        #1;
        check_eq("rst_wait.dm_req_rst", 32'(dm_req), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0; ex_valid = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1234_5678;
        #1;
        check_eq("rst_wait.dm_req_after", 32'(dm_req), 32'd0);
        @(negedge CLK);
        check_eq("rst_wait.stall", 32'(mem_stall), 32'd0);
        @(posedge CLK);
        #1;
        dm_rvalid = 1'b0;
        check_wb_zero("rst_wait");
        run_instr("alu_after_rst", 0, 32'hBEEF, 0, 32'h2004, 5'd4, 2'd1, 1'b1, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 15);
            a = $urandom;
            run_instr("rand", op, a, $urandom, $urandom, 5'($urandom_range(0, 31)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) bubble();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
